// File: rtl/alu_acc_pipe.sv
// alu_acc_pipe: parametrised 8-op ALU with an internal accumulator, {N,Z,C,V}
// status flags and a valid/ready handshake feeding a one-deep result register.
// The accumulator stands in for the old external A operand.
// Optional build macro ALU_ACC_PIPE_SAT_EN: ADD, SUB and ADD_A saturate signed
// instead of wrapping. V still reports the overflow, and C is the unsaturated
// carry/borrow.
module alu_acc_pipe #(
    parameter int               WIDTH    = 32,
    parameter logic [WIDTH-1:0] ACC_INIT = '0
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_valid,
    output logic             o_ready,
    input  logic [2:0]       i_select,
    input  logic [WIDTH-1:0] i_in0,
    input  logic [WIDTH-1:0] i_in1,
    input  logic             i_acc_load,
    input  logic [WIDTH-1:0] i_acc_wdata,
    output logic             o_valid,
    input  logic             i_ready,
    output logic [WIDTH-1:0] o_out,
    output logic [3:0]       o_flags,
    output logic [WIDTH-1:0] o_acc
);

    typedef enum logic [2:0] {
        OP_ADD_A = 3'b000,
        OP_AND   = 3'b001,
        OP_XOR   = 3'b010,
        OP_OR    = 3'b011,
        OP_DEC_A = 3'b100,
        OP_ADD   = 3'b101,
        OP_SUB   = 3'b110,
        OP_INC_A = 3'b111
    } op_e;

    localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

    // Signed overflow from operand and result sign bits. On a subtract the
    // second operand's sign is effectively inverted.
    function automatic logic signed_ovf(input logic a_msb, input logic b_msb,
                                        input logic r_msb, input logic is_sub);
        logic b_eff;
        b_eff = is_sub ? ~b_msb : b_msb;
        return (a_msb == b_eff) && (r_msb != a_msb);
    endfunction

`ifdef ALU_ACC_PIPE_SAT_EN
    // Clamp value for a saturated overflow. An overflow can only move away from
    // the first operand's sign, so that sign selects the rail.
    function automatic logic signed [WIDTH-1:0] sat_clamp(input logic neg);
        logic signed [WIDTH-1:0] r;
        r = neg ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
        return r;
    endfunction
`endif

    op_e                     op_p0;
    logic                    accept_p0;
    logic                    vld_p1;
    logic signed [WIDTH-1:0] op_a_p0;
    logic signed [WIDTH-1:0] op_b_p0;
    logic                    is_arith_p0;
    logic                    is_sub_p0;
    logic                    sat_ok_p0;
    logic                    acc_op_p0;
    logic        [WIDTH:0]   ext_p0;
    logic signed [WIDTH-1:0] logic_p0;
    logic signed [WIDTH-1:0] res_p0;
    logic                    c_p0;
    logic                    v_p0;
    logic        [3:0]       flags_p0;
    logic        [WIDTH-1:0] out_p1;
    logic        [3:0]       flags_p1;
    logic        [WIDTH-1:0] acc_q;

    assign op_p0     = op_e'(i_select);
    assign o_ready   = !vld_p1 || i_ready;
    assign accept_p0 = i_valid && o_ready;

    // Stage p0: operand selection, arithmetic, optional saturation and flags
    always_comb begin
        op_a_p0     = i_in0;
        op_b_p0     = i_in1;
        is_arith_p0 = 1'b0;
        is_sub_p0   = 1'b0;
        sat_ok_p0   = 1'b0;
        acc_op_p0   = 1'b0;
        logic_p0    = '0;
        case (op_p0)
            OP_ADD_A: begin
                op_a_p0     = acc_q;
                op_b_p0     = i_in0;
                is_arith_p0 = 1'b1;
                sat_ok_p0   = 1'b1;
                acc_op_p0   = 1'b1;
            end
            OP_AND: logic_p0 = i_in0 & i_in1;
            OP_XOR: logic_p0 = i_in0 ^ i_in1;
            OP_OR:  logic_p0 = i_in0 | i_in1;
            OP_DEC_A: begin
                op_a_p0     = acc_q;
                op_b_p0     = ONE;
                is_arith_p0 = 1'b1;
                is_sub_p0   = 1'b1;
                acc_op_p0   = 1'b1;
            end
            OP_ADD: begin
                is_arith_p0 = 1'b1;
                sat_ok_p0   = 1'b1;
            end
            OP_SUB: begin
                is_arith_p0 = 1'b1;
                is_sub_p0   = 1'b1;
                sat_ok_p0   = 1'b1;
            end
            OP_INC_A: begin
                op_a_p0     = acc_q;
                op_b_p0     = ONE;
                is_arith_p0 = 1'b1;
                acc_op_p0   = 1'b1;
            end
            default: logic_p0 = '0;
        endcase

        // One extra bit holds the carry-out, or the borrow when subtracting.
        if (is_sub_p0)
            ext_p0 = {1'b0, op_a_p0} - {1'b0, op_b_p0};
        else
            ext_p0 = {1'b0, op_a_p0} + {1'b0, op_b_p0};

        c_p0 = is_arith_p0 && ext_p0[WIDTH];
        v_p0 = is_arith_p0 && signed_ovf(op_a_p0[WIDTH-1], op_b_p0[WIDTH-1],
                                         ext_p0[WIDTH-1], is_sub_p0);

        res_p0 = is_arith_p0 ? $signed(ext_p0[WIDTH-1:0]) : logic_p0;
`ifdef ALU_ACC_PIPE_SAT_EN
        if (sat_ok_p0 && v_p0)
            res_p0 = sat_clamp(op_a_p0[WIDTH-1]);
`endif
        flags_p0 = {res_p0[WIDTH-1], (res_p0 == '0), c_p0, v_p0};
    end

    // Stage p1: result register, loaded on accept and held under backpressure
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            vld_p1   <= 1'b0;
            out_p1   <= '0;
            flags_p1 <= '0;
        end else if (accept_p0) begin
            vld_p1   <= 1'b1;
            out_p1   <= res_p0;
            flags_p1 <= flags_p0;
        end else if (i_ready) begin
            vld_p1   <= 1'b0;
        end
    end

    // Accumulator: an explicit load beats an accumulator-op writeback
    always_ff @(posedge i_clk) begin
        if (i_reset)
            acc_q <= ACC_INIT;
        else if (i_acc_load)
            acc_q <= i_acc_wdata;
        else if (accept_p0 && acc_op_p0)
            acc_q <= res_p0;
    end

    assign o_valid = vld_p1;
    assign o_out   = out_p1;
    assign o_flags = flags_p1;
    assign o_acc   = acc_q;

    // sat_ok_p0 only steers the optional saturation path.
    logic unused_p0;
    assign unused_p0 = sat_ok_p0;

endmodule
